// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad operand entry block: key codes,
// operator encodings, entry FSM state encodings and the sweep result type.
package keypad_pkg;

    // Key codes as produced by the scanner: {row[1:0], col[1:0]}
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_AND = 4'hC;
    localparam logic [3:0] KEY_OR  = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    // Operator select encodings driven to the calculator
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Entry FSM state encodings (also exported for display)
    localparam logic [1:0] S_A  = 2'b00;
    localparam logic [1:0] S_OP = 2'b01;
    localparam logic [1:0] S_B  = 2'b10;
    localparam logic [1:0] S_EQ = 2'b11;

    // One full-sweep keypad observation; present=0 means no single key.
    typedef struct packed {
        logic       present;
        logic [3:0] code;
    } sweep_result_t;

    localparam sweep_result_t RESULT_NONE = '{present: 1'b0, code: 4'h0};

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'h9);
    endfunction

    function automatic logic is_operator(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_OR);
    endfunction

    function automatic logic [1:0] op_of_key(input logic [3:0] k);
        logic [1:0] op;
        case (k)
            KEY_ADD: op = OP_ADD;
            KEY_SUB: op = OP_SUB;
            KEY_AND: op = OP_AND;
            default: op = OP_OR;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Keypad column scanner: drives one column low at a time, synchronizes the
// row inputs, forms a key result per full sweep, debounces it and emits a
// one-cycle press pulse with the key code on each NONE -> key transition.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS      = 100000,
    parameter int DEBOUNCE_SWEEPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       press,
    output logic [3:0] key
);

    localparam int TICK_W  = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int MATCH_W = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(SCAN_TICKS - 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(DEBOUNCE_SWEEPS);

    logic [TICK_W-1:0]  tick_q;
    logic [1:0]         col_idx_q;
    logic [3:0]         col_q;
    logic [3:0]         row_meta_q;
    logic [3:0]         row_sync_q;
    logic [1:0]         hit_cnt_q;
    logic [3:0]         hit_code_q;
    sweep_result_t      last_q;
    logic [MATCH_W-1:0] match_q;
    sweep_result_t      stable_q;
    logic               press_q;
    logic [3:0]         key_q;

    logic               col_last;
    logic               sweep_done;
    logic [3:0]         row_act;
    logic [2:0]         col_cnt;
    logic [1:0]         col_row;
    logic [1:0]         base_cnt;
    logic [2:0]         sum_cnt;
    logic [1:0]         acc_cnt_d;
    logic [3:0]         acc_code_d;
    sweep_result_t      sweep_result;
    sweep_result_t      last_d;
    logic [MATCH_W-1:0] match_d;
    sweep_result_t      stable_d;
    logic               press_d;
    logic [3:0]         key_d;

    assign col_last   = (tick_q == TICK_LAST);
    assign sweep_done = col_last && (col_idx_q == 2'd3);

    // Column scan: hold each column SCAN_TICKS clocks, then rotate the low bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q    <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
        end else if (col_last) begin
            tick_q    <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            col_q     <= {col_q[2:0], col_q[3]};
        end else begin
            tick_q    <= tick_q + TICK_W'(1);
        end
    end

    // Two-flop synchronizer; rows idle high through the external pull-ups
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Count active rows in the current column and remember which one
    always_comb begin
        row_act = ~row_sync_q;
        col_cnt = 3'd0;
        col_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_act[r]) begin
                col_cnt = col_cnt + 3'd1;
                col_row = 2'(r);
            end
        end
    end

    // Accumulate hits over the sweep; count saturates at 2 (means "many")
    always_comb begin
        base_cnt   = (col_idx_q == 2'd0) ? 2'd0 : hit_cnt_q;
        sum_cnt    = {1'b0, base_cnt} + col_cnt;
        acc_cnt_d  = (sum_cnt > 3'd2) ? 2'd2 : sum_cnt[1:0];
        acc_code_d = (col_cnt == 3'd1) ? {col_row, col_idx_q} : hit_code_q;
        sweep_result = (acc_cnt_d == 2'd1) ? '{present: 1'b1, code: acc_code_d}
                                           : RESULT_NONE;
    end

    // Sweep accumulator registers, updated on the last clock of each column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= 2'd0;
            hit_code_q <= 4'h0;
        end else if (col_last) begin
            hit_cnt_q  <= acc_cnt_d;
            hit_code_q <= acc_code_d;
        end
    end

    // Debounce: stable result follows only after enough identical sweeps
    always_comb begin
        last_d   = last_q;
        match_d  = match_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        key_d    = key_q;
        if (sweep_done) begin
            if (sweep_result == last_q) begin
                if (match_q != MATCH_FULL) begin
                    match_d = match_q + MATCH_W'(1);
                end
            end else begin
                last_d  = sweep_result;
                match_d = MATCH_W'(1);
            end
            if (match_d == MATCH_FULL) begin
                stable_d = sweep_result;
                // Only NONE -> key counts; key -> other key is silent
                if (!stable_q.present && sweep_result.present) begin
                    press_d = 1'b1;
                    key_d   = sweep_result.code;
                end
            end
        end
    end

    // Debounce history, stable result and press pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= RESULT_NONE;
            match_q  <= '0;
            stable_q <= RESULT_NONE;
            press_q  <= 1'b0;
            key_q    <= 4'h0;
        end else begin
            last_q   <= last_d;
            match_q  <= match_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            key_q    <= key_d;
        end
    end

    assign col   = col_q;
    assign press = press_q;
    assign key   = key_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// Calculator operand entry: takes debounced key presses from the scanner
// and walks A -> operator -> B -> '=' to capture an operand set.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS      = 100000,
    parameter int DEBOUNCE_SWEEPS = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_A,
    output logic [3:0] o_B,
    output logic [1:0] o_selOperator,
    output logic       o_valid,
    output logic [1:0] o_state
);

    logic       key_press;
    logic [3:0] key_code;

    logic [1:0] state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;

    keypad_scanner #(
        .SCAN_TICKS      (SCAN_TICKS),
        .DEBOUNCE_SWEEPS (DEBOUNCE_SWEEPS)
    ) u_scanner (
        .clk   (i_clk),
        .rst   (i_reset),
        .row   (i_row),
        .col   (o_col),
        .press (key_press),
        .key   (key_code)
    );

    // Entry FSM next state; keys not listed for a state are ignored
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        if (key_press) begin
            if (key_code == KEY_CLR) begin
                state_d = S_A;
                a_d     = 4'h0;
                b_d     = 4'h0;
                sel_d   = OP_ADD;
            end else begin
                case (state_q)
                    S_A: begin
                        if (is_digit(key_code)) begin
                            a_d     = key_code;
                            state_d = S_OP;
                        end
                    end
                    S_OP: begin
                        if (is_digit(key_code)) begin
                            a_d = key_code;
                        end else if (is_operator(key_code)) begin
                            sel_d   = op_of_key(key_code);
                            state_d = S_B;
                        end
                    end
                    S_B: begin
                        if (is_digit(key_code)) begin
                            b_d     = key_code;
                            state_d = S_EQ;
                        end else if (is_operator(key_code)) begin
                            sel_d = op_of_key(key_code);
                        end
                    end
                    default: begin
                        if (is_digit(key_code)) begin
                            b_d = key_code;
                        end else if (is_operator(key_code)) begin
                            sel_d = op_of_key(key_code);
                        end else if (key_code == KEY_EQ) begin
                            // Operands stay on the outputs for the calculator
                            valid_d = 1'b1;
                            state_d = S_A;
                        end
                    end
                endcase
            end
        end
    end

    // Entry FSM and operand registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_A;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            sel_q   <= OP_ADD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign o_A           = a_q;
    assign o_B           = b_q;
    assign o_selOperator = sel_q;
    assign o_valid       = valid_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed bench for keypad_operand_entry with a 4x4 switch-matrix model.
module tb_keypad_operand_entry;

    localparam int ST    = 4;
    localparam int DB    = 2;
    localparam int SWEEP = 4 * ST;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pressed = 16'h0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic [1:0]  sel;
    logic        valid;
    logic [1:0]  state;

    int n_checks = 0;
    int n_pass   = 0;
    int press_cnt = 0;
    int valid_cnt = 0;

    keypad_operand_entry #(
        .SCAN_TICKS      (ST),
        .DEBOUNCE_SWEEPS (DB)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_row         (row),
        .o_col         (col),
        .o_A           (op_a),
        .o_B           (op_b),
        .o_selOperator (sel),
        .o_valid       (valid),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    // Switch matrix: key code {r,c} shorts row r low while column c is driven low
    function automatic logic [3:0] keypad_rows(input logic [3:0] cols, input logic [15:0] keys);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
        return rows;
    endfunction

    assign row = keypad_rows(col, pressed);

    always @(posedge clk) begin
        if (dut.key_press === 1'b1) press_cnt++;
        if (valid === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic hold(input logic [15:0] mask, input int sweeps);
        pressed = mask;
        repeat (sweeps * SWEEP) @(posedge clk);
    endtask

    task automatic tap(input int k);
        hold(16'd1 << k, 3);
        hold(16'h0, 3);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_col", col, 4'b1110);
        check("rst_a", op_a, 0);
        check("rst_b", op_b, 0);
        check("rst_sel", sel, 0);
        check("rst_valid", valid, 0);
        check("rst_state", state, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // 3 + 5 =
        tap(3);
        check("a_3", op_a, 3);
        check("st_op", state, 1);
        tap(4'hA);
        check("sel_add", sel, 0);
        check("st_b", state, 2);
        tap(5);
        check("b_5", op_b, 5);
        check("st_eq", state, 3);
        tap(4'hE);
        check("eq_state", state, 0);
        check("eq_valid", valid_cnt, 1);
        check("eq_a_held", op_a, 3);
        check("eq_b_held", op_b, 5);
        check("eq_sel_held", sel, 0);
        check("press_4", press_cnt, 4);

        // Ignored keys in S_A / S_OP / S_B
        tap(4'hE);
        check("sa_eq_state", state, 0);
        tap(4'hB);
        check("sa_op_state", state, 0);
        check("sa_op_sel", sel, 0);
        tap(8);
        check("a_8", op_a, 8);
        tap(4'hE);
        check("sop_eq_state", state, 1);
        tap(4'hB);
        check("sel_sub", sel, 1);
        check("st_b2", state, 2);
        tap(4'hE);
        check("sb_eq_state", state, 2);
        check("ign_valid", valid_cnt, 1);
        check("press_10", press_cnt, 10);

        // Two keys at once: no event
        hold((16'd1 << 1) | (16'd1 << 6), 3);
        hold(16'h0, 3);
        @(negedge clk);
        check("dual_press", press_cnt, 10);
        check("dual_state", state, 2);
        check("dual_b", op_b, 5);

        tap(4'hF);
        check("clr_a", op_a, 0);
        check("clr_b", op_b, 0);
        check("clr_state", state, 0);

        // 2 - 4, overwrite in S_EQ, then clear
        tap(2);
        tap(4'hB);
        tap(4);
        check("b_4", op_b, 4);
        check("st_eq2", state, 3);
        tap(9);
        check("eq_b_9", op_b, 9);
        tap(4'hD);
        check("eq_sel_or", sel, 3);
        check("eq_hold_state", state, 3);
        tap(4'hF);
        check("clr2_a", op_a, 0);
        check("clr2_b", op_b, 0);
        check("clr2_sel", sel, 0);
        check("clr2_state", state, 0);
        check("clr2_valid", valid_cnt, 1);
        check("press_17", press_cnt, 17);

        // Bounce on key 7, then held
        for (int i = 0; i < 4; i++) begin
            pressed[7] = ~pressed[7];
            repeat (5) @(posedge clk);
        end
        tap(7);
        check("bounce_press", press_cnt, 18);
        check("bounce_a", op_a, 7);

        // Key 4 rolled directly onto '&' without release: only the 4 counts
        hold(16'd1 << 4, 3);
        hold(16'd1 << 12, 3);
        hold(16'h0, 3);
        @(negedge clk);
        check("roll_press", press_cnt, 19);
        check("roll_a", op_a, 4);
        check("roll_state", state, 1);
        check("roll_sel", sel, 0);

        // Asynchronous reset mid-column with key held
        pressed = 16'd1 << 5;
        for (int i = 0; i < 100 && col !== 4'b1011; i++) @(negedge clk);
        check("col_seen", col, 4'b1011);
        #2 rst = 1'b1;
        #1;
        check("arst_col", col, 4'b1110);
        check("arst_a", op_a, 0);
        check("arst_state", state, 0);
        check("arst_sel", sel, 0);
        check("arst_valid", valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        hold(16'h0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
